vscale_htif_pcr_host: RTL

Host-side initiator for the HTIF PCR request/response channel into the core's CSR file. It arbitrates between explicit host commands, such as writing `from_host` or reading and writing any CSR, and an autonomous poller that periodically reads `to_host`. Nonzero `to_host` values are buffered on a dedicated output stream. It sits in the host/test-harness domain, wired port-for-port to the CSR file's `htif_pcr_*` pins.

---
 rtl/vscale_htif_pcr_host.sv | 110 +++++++++++
 1 files changed

// File: rtl/vscale_htif_pcr_host.sv
// rtl/vscale_htif_pcr_host.sv - HTIF PCR initiator: host CSR commands plus periodic to_host poller.
module vscale_htif_pcr_host #(
  parameter int                    ADDR_WIDTH    = 12,
  parameter int                    DATA_WIDTH    = 64,
  parameter logic [ADDR_WIDTH-1:0] TO_HOST_ADDR  = 12'h780,
  parameter int                    POLL_INTERVAL = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rw,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  tohost_valid,
  input  logic                  tohost_ready,
  output logic [DATA_WIDTH-1:0] tohost_data,
  output logic                  pcr_req_valid,
  input  logic                  pcr_req_ready,
  output logic                  pcr_req_rw,
  output logic [ADDR_WIDTH-1:0] pcr_req_addr,
  output logic [DATA_WIDTH-1:0] pcr_req_data,
  input  logic                  pcr_resp_valid,
  output logic                  pcr_resp_ready,
  input  logic [DATA_WIDTH-1:0] pcr_resp_data
);

  localparam int                CNT_W       = $clog2(POLL_INTERVAL + 1);
  localparam logic [CNT_W-1:0]  POLL_RELOAD = CNT_W'(POLL_INTERVAL - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_t;

  state_t           state;
  logic             src_poll;
  logic [CNT_W-1:0] poll_cnt;
  logic             poll_due;

  assign cmd_ready      = (state == IDLE);
  assign pcr_req_valid  = (state == REQ);
  assign pcr_resp_ready = (state == WAIT);
  assign rsp_valid      = (state == RSP);

  // The CSR file clears to_host on read, so a poll while the buffer is full would lose data.
  assign poll_due = (poll_cnt == '0) && !tohost_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      src_poll     <= 1'b0;
      poll_cnt     <= POLL_RELOAD;
      pcr_req_rw   <= 1'b0;
      pcr_req_addr <= '0;
      pcr_req_data <= '0;
      rsp_data     <= '0;
      tohost_valid <= 1'b0;
      tohost_data  <= '0;
    end else begin
      if (tohost_valid && tohost_ready)
        tohost_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (poll_cnt != '0)
            poll_cnt <= poll_cnt - 1'b1;
          if (cmd_valid) begin
            pcr_req_rw   <= cmd_rw;
            pcr_req_addr <= cmd_addr;
            pcr_req_data <= cmd_rw ? cmd_wdata : '0;
            src_poll     <= 1'b0;
            state        <= REQ;
          end else if (poll_due) begin
            pcr_req_rw   <= 1'b0;
            pcr_req_addr <= TO_HOST_ADDR;
            pcr_req_data <= '0;
            src_poll     <= 1'b1;
            state        <= REQ;
          end
        end
        REQ: begin
          if (pcr_req_ready)
            state <= WAIT;
        end
        WAIT: begin
          if (pcr_resp_valid) begin
            if (src_poll) begin
              if (pcr_resp_data != '0) begin
                tohost_valid <= 1'b1;
                tohost_data  <= pcr_resp_data;
              end
              poll_cnt <= POLL_RELOAD;
              state    <= IDLE;
            end else begin
              rsp_data <= pcr_resp_data;
              state    <= RSP;
            end
          end
        end
        RSP: begin
          if (rsp_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
